// File: rtl/avalon_multichannel_interval_timer.sv
// NUM_CH independent prescaled down-counting timers behind one Avalon-MM slave.
// Reads have a fixed 1-cycle latency and writes complete in one cycle (no waitrequest).
module avalon_multichannel_interval_timer #(
  parameter int NUM_CH         = 4,
  parameter int COUNTER_WIDTH  = 32,
  parameter int PRESCALE_WIDTH = 16,
  parameter int PERIOD_RESET   = 49999,
  localparam int CH_BITS       = (NUM_CH > 2) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CH_BITS+2:0]   address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  output logic                 irq
);

  localparam logic [COUNTER_WIDTH-1:0] PERIOD_INIT = COUNTER_WIDTH'(PERIOD_RESET);

  logic [2:0]         reg_sel;
  logic [CH_BITS-1:0] ch_sel;
  logic               wr_en;

  assign reg_sel = address[2:0];
  assign ch_sel  = address[CH_BITS+2:3];
  assign wr_en   = chipselect & ~write_n;

  logic [COUNTER_WIDTH-1:0]  counter  [NUM_CH];
  logic [COUNTER_WIDTH-1:0]  period   [NUM_CH];
  logic [COUNTER_WIDTH-1:0]  snapshot [NUM_CH];
  logic [PRESCALE_WIDTH-1:0] prescale [NUM_CH];
  logic [PRESCALE_WIDTH-1:0] pcount   [NUM_CH];

  logic [NUM_CH-1:0] ito, cont, run, to, force_reload;
  logic [NUM_CH-1:0] ch_wr, status_wr, control_wr, period_wr, snap_wr, prescale_wr;
  logic [NUM_CH-1:0] start, stop, tick, expire, irq_vec;
  logic [31:0]       rd_mux;

  always_comb begin
    ch_wr       = '0;
    status_wr   = '0;
    control_wr  = '0;
    period_wr   = '0;
    snap_wr     = '0;
    prescale_wr = '0;
    start       = '0;
    stop        = '0;
    tick        = '0;
    expire      = '0;
    irq_vec     = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      ch_wr[n]       = wr_en && (ch_sel == CH_BITS'(n));
      status_wr[n]   = ch_wr[n] && (reg_sel == 3'd0);
      control_wr[n]  = ch_wr[n] && (reg_sel == 3'd1);
      period_wr[n]   = ch_wr[n] && (reg_sel == 3'd2);
      snap_wr[n]     = ch_wr[n] && (reg_sel == 3'd3);
      prescale_wr[n] = ch_wr[n] && (reg_sel == 3'd4);
      start[n]       = control_wr[n] && writedata[2];
      stop[n]        = control_wr[n] && writedata[3];
      tick[n]        = run[n] && (pcount[n] == prescale[n]);
      // A pending reload after a period write overrides any tick this cycle
      expire[n]      = tick[n] && (counter[n] == '0) && !force_reload[n];
      irq_vec[n]     = to[n] && ito[n];
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_sel == CH_BITS'(n)) begin
        case (reg_sel)
          3'd0:    rd_mux = {30'd0, run[n], to[n]};
          3'd1:    rd_mux = {30'd0, cont[n], ito[n]};
          3'd2:    rd_mux = 32'(period[n]);
          3'd3:    rd_mux = 32'(snapshot[n]);
          3'd4:    rd_mux = 32'(prescale[n]);
          3'd5:    rd_mux = 32'(irq_vec);
          default: rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < NUM_CH; n++) begin
        counter[n]  <= PERIOD_INIT;
        period[n]   <= PERIOD_INIT;
        snapshot[n] <= '0;
        prescale[n] <= '0;
        pcount[n]   <= '0;
      end
      ito          <= '0;
      cont         <= '0;
      run          <= '0;
      to           <= '0;
      force_reload <= '0;
      readdata     <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (period_wr[n])   period[n]   <= writedata[COUNTER_WIDTH-1:0];
        if (prescale_wr[n]) prescale[n] <= writedata[PRESCALE_WIDTH-1:0];
        if (snap_wr[n])     snapshot[n] <= counter[n];
        if (control_wr[n]) begin
          ito[n]  <= writedata[0];
          cont[n] <= writedata[1];
        end

        if (start[n] || stop[n] || period_wr[n] || tick[n])
          pcount[n] <= '0;
        else if (run[n])
          pcount[n] <= pcount[n] + 1'b1;

        if (force_reload[n])
          counter[n] <= period[n];
        else if (tick[n])
          counter[n] <= (counter[n] == '0) ? period[n] : counter[n] - 1'b1;

        // START wins over a same-write STOP and over a one-shot expiry
        if (start[n])
          run[n] <= 1'b1;
        else if (force_reload[n] || stop[n] || (expire[n] && !cont[n]))
          run[n] <= 1'b0;

        if (expire[n])
          to[n] <= 1'b1;
        else if (status_wr[n])
          to[n] <= 1'b0;
      end
      force_reload <= period_wr;
      readdata     <= rd_mux;
    end
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_avalon_multichannel_interval_timer.sv
// Directed bench for the multichannel interval timer, built with three channels.
module tb_avalon_multichannel_interval_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int n_chk = 0;
  int n_bad = 0;

  avalon_multichannel_interval_timer #(
    .NUM_CH(3),
    .COUNTER_WIDTH(32),
    .PRESCALE_WIDTH(16),
    .PERIOD_RESET(49999)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Each access occupies exactly one clock edge and returns #1 after it.
  task automatic wr(input int ch, input int rg, input logic [31:0] d);
    address    = {2'(ch), 3'(rg)};
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd_chk(input string tag, input int ch, input int rg, input logic [31:0] exp);
    logic [31:0] d;
    address    = {2'(ch), 3'(rg)};
    chipselect = 1'b1;
    @(posedge clk);
    #1;
    d          = readdata;
    chipselect = 1'b0;
    chk(tag, d, exp);
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    cycles(2);
    reset = 1'b0;

    // Reset state
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("rst_period0", 0, 2, 32'd49999);
    rd_chk("rst_status0", 0, 0, 32'd0);
    rd_chk("rst_pending0", 0, 5, 32'd0);

    // ch1: period 3, prescale 0, continuous with interrupt
    wr(1, 2, 32'd3);
    wr(1, 4, 32'd0);
    wr(1, 1, 32'd7);
    chk("ch1_irq_at_run", {31'd0, irq}, 32'd0);
    cycles(3);
    chk("ch1_irq_before_to", {31'd0, irq}, 32'd0);
    cycles(1);
    chk("ch1_irq_first_to", {31'd0, irq}, 32'd1);
    rd_chk("ch1_pending", 1, 5, 32'h2);
    rd_chk("ch1_status_to_run", 1, 0, 32'd3);
    wr(1, 0, 32'd0);
    chk("ch1_irq_cleared", {31'd0, irq}, 32'd0);
    cycles(1);
    chk("ch1_irq_second_to", {31'd0, irq}, 32'd1);
    rd_chk("ch1_status_still_run", 1, 0, 32'd3);
    rd_chk("ch1_control_readback", 1, 1, 32'd3);
    wr(1, 0, 32'd0);
    chk("ch1_irq_cleared2", {31'd0, irq}, 32'd0);
    wr(1, 0, 32'd0);
    chk("ch1_clear_vs_to", {31'd0, irq}, 32'd1);
    rd_chk("ch0_pending_mirror", 0, 5, 32'h2);
    wr(1, 1, 32'd8);
    chk("ch1_ito_off_irq", {31'd0, irq}, 32'd0);
    wr(1, 1, 32'd12);
    rd_chk("ch1_start_stop_run", 1, 0, 32'd3);
    wr(1, 1, 32'd8);
    wr(1, 0, 32'd0);

    // ch2: period 2, prescale 4, one-shot
    wr(2, 2, 32'd2);
    wr(2, 4, 32'd4);
    wr(2, 1, 32'd4);
    cycles(14);
    rd_chk("ch2_run_before_to", 2, 0, 32'd2);
    rd_chk("ch2_to_after_15", 2, 0, 32'd1);
    wr(2, 3, 32'd0);
    rd_chk("ch2_counter_reloaded", 2, 3, 32'd2);
    cycles(10);
    wr(2, 3, 32'd0);
    rd_chk("ch2_counter_holds", 2, 3, 32'd2);
    chk("ch2_no_irq", {31'd0, irq}, 32'd0);

    // ch0: period 100, snapshot after 10 ticks, then period rewrite mid-run
    wr(0, 2, 32'd100);
    wr(0, 4, 32'd0);
    wr(0, 1, 32'd4);
    cycles(10);
    wr(0, 3, 32'd0);
    rd_chk("ch0_snap_90", 0, 3, 32'd90);
    wr(0, 2, 32'd5);
    rd_chk("ch0_run_before_reload", 0, 0, 32'd2);
    rd_chk("ch0_run_after_reload", 0, 0, 32'd0);
    wr(0, 3, 32'd0);
    rd_chk("ch0_counter_5", 0, 3, 32'd5);

    // Channel 3 does not exist with three channels
    wr(3, 2, 32'd7);
    wr(3, 1, 32'd7);
    rd_chk("ch3_period_zero", 3, 2, 32'd0);
    rd_chk("ch3_status_zero", 3, 0, 32'd0);
    rd_chk("ch3_pending_zero", 3, 5, 32'd0);
    rd_chk("ch0_period_intact", 0, 2, 32'd5);
    rd_chk("ch0_status_intact", 0, 0, 32'd0);

    // Reset while two channels run
    wr(0, 1, 32'd7);
    wr(1, 1, 32'd7);
    cycles(10);
    chk("pre_reset_irq", {31'd0, irq}, 32'd1);
    reset = 1'b1;
    cycles(1);
    reset = 1'b0;
    chk("post_reset_irq", {31'd0, irq}, 32'd0);
    chk("post_reset_readdata", readdata, 32'd0);
    rd_chk("post_reset_status0", 0, 0, 32'd0);
    rd_chk("post_reset_control0", 0, 1, 32'd0);
    rd_chk("post_reset_period1", 1, 2, 32'd49999);
    rd_chk("post_reset_status1", 1, 0, 32'd0);
    rd_chk("post_reset_prescale2", 2, 4, 32'd0);
    rd_chk("post_reset_snap0", 0, 3, 32'd0);
    rd_chk("post_reset_pending", 1, 5, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/avalon_multichannel_interval_timer.md
Name: avalon_multichannel_interval_timer

Overview:
- Parametrised successor to the single-channel 16-bit-bus interval timer.
- Provides NUM_CH independent down-counting timers behind one Avalon-MM slave, each with programmable period, clock prescaler, one-shot/continuous mode, and snapshot.
- Per-channel timeout interrupts are ORed onto a single irq line for the Nios II; a global pending register identifies the source.

Parameters:
- NUM_CH, 4, number of timer channels (1..16).
- COUNTER_WIDTH, 32, width of counter, period and snapshot (1..32); narrower values are zero-extended on read.
- PRESCALE_WIDTH, 16, prescaler register width (1..32).
- PERIOD_RESET, 49999, reset value of every period register and counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  CH_BITS+3  {channel, reg}; CH_BITS = max(1, clog2(NUM_CH)).
- chipselect  in  1  slave select.
- write_n  in  1  active-low write.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  OR of all per-channel irqs.

Behaviour:
Register map (reg field):
- 0 STATUS: bit0 TO, bit1 RUN. Any write clears TO.
- 1 CONTROL: bits[1:0] stored (ITO, CONT). Bit2 START and bit3 STOP are write-only strobes and read as 0.
- 2 PERIOD.
- 3 SNAP: a write copies the live counter into the snapshot; a read returns the snapshot.
- 4 PRESCALE.
- 5 PENDING: read-only, NUM_CH bits; bit n = TO_n & ITO_n. Identical on every channel.
- 6, 7 and channel numbers >= NUM_CH: read 0, writes ignored.

Bus and reset:
- Write strobe = chipselect & ~write_n.
- Reads have fixed 1-cycle latency: readdata registered every cycle from the mux regardless of chipselect. No waitrequest.
- Reset (synchronous): counter = PERIOD_RESET, period = PERIOD_RESET, prescale = 0, prescaler count = 0, control = 0, RUN = 0, TO = 0, snapshot = 0, readdata = 0, irq = 0.

Prescaler (per channel):
- pcount increments while RUN.
- tick = RUN & (pcount == PRESCALE); pcount wraps to 0 on tick.
- PRESCALE = 0 gives a tick every clock.
- pcount is cleared on START, STOP, or a period write.

Counter (per channel), evaluated in priority order:
1. force_reload (registered one cycle after a PERIOD write): counter <= period, RUN <= 0.
2. Otherwise, on tick:
   - If counter == 0: counter <= period, TO <= 1, and RUN <= 0 if CONT = 0.
   - Else: counter <= counter - 1.
- Period N therefore gives a timeout every (N+1)*(PRESCALE+1) clocks.
- Period 0 in CONT mode sets TO on every tick.

Run control:
- START sets RUN on the following edge and takes priority over a same-write STOP and over a same-cycle one-shot expiry.
- START while already running does not reload the counter.
- STOP clears RUN; the counter holds its value.

Status and interrupts:
- If a TO set and a STATUS write occur in the same cycle, the set wins (no lost events).
- irq_n = TO_n & ITO_n, combinational from registers.
- irq = |irq_n.

Snapshot:
- A snapshot write in the same cycle as a decrement captures the pre-decrement value.

Widths:
- period, snapshot and PRESCALE writes use writedata[COUNTER_WIDTH-1:0] / writedata[PRESCALE_WIDTH-1:0]; upper bits are ignored.

Test Plan:
- Reset, then read ch0 PERIOD, STATUS and PENDING -> 49999, 0, 0 (each valid one cycle after the read address); irq = 0.
- ch1 PERIOD = 3, PRESCALE = 0, CONTROL = ITO|CONT|START -> TO_1 first sets 4 clocks after RUN; irq rises; PENDING = 0b0010; STATUS write clears TO_1; next TO 4 clocks later; RUN stays 1.
- ch2 PERIOD = 2, PRESCALE = 4, one-shot START -> TO sets after 15 clocks, RUN = 0, counter = 2 and stays there.
- ch0 running with PERIOD = 100: write SNAP after 10 ticks -> SNAP reads 90; write PERIOD = 5 mid-run -> RUN = 0 and counter = 5 two cycles later.
- Status clear in the same cycle as a timeout -> TO remains 1. START|STOP written together -> RUN = 1.
- NUM_CH = 3, read and write channel 3 -> reads 0, no state change.
- Assert reset while two channels are running -> all registers return to reset values on the next edge and irq = 0.
